// File: rtl/hub75_rx.sv
// HUB75 cable receiver / panel emulator: rebuilds each latched row as framebuffer pixel writes.
// Optional build macro HUB75_RX_BLANK_QUAL_EN: latches are accepted only while the panel is blanked.
//
// state | meaning
// IDLE  | waiting for a latch edge; rows accumulate in the shift register
// EMIT  | presenting the held row, upper/lower pixel per column
module hub75_rx #(
  parameter int WIDTH       = 64,
  parameter int ADDR_BITS   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     latch,
  input  logic                     blank,
  input  logic [ADDR_BITS-1:0]     addry,
  input  logic [2:0]               rgb0,
  input  logic [2:0]               rgb1,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [$clog2(WIDTH)-1:0] wr_x,
  output logic [ADDR_BITS:0]       wr_y,
  output logic [2:0]               wr_rgb,
  output logic                     frame_start,
  output logic                     len_err,
  output logic                     overrun
);

  localparam int XW = $clog2(WIDTH);
  localparam int CW = $clog2(2*WIDTH+1);
  localparam int BW = ADDR_BITS + 9;
  localparam logic [CW-1:0] CNT_MAX = CW'(2*WIDTH);
  localparam logic [CW-1:0] CNT_ROW = CW'(WIDTH);
  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH-1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                         state;
  logic [SYNC_STAGES-1:0][BW-1:0] sync_q;
  logic [BW-1:0]                  cab;
  logic [5:0]                     cab_rgb;
  logic [ADDR_BITS-1:0]           cab_addry;
  logic                           cab_sclk, cab_latch, cab_blank;
  logic                           sclk_d, latch_d, sclk_rise, latch_rise;
  logic                           latch_ok, latch_bad;
  logic [WIDTH-1:0][5:0]          sr, sr_next, hold;
  logic [CW-1:0]                  cnt, cnt_next;
  logic [ADDR_BITS-1:0]           prev_addry;
  logic                           lower;

  assign cab        = sync_q[SYNC_STAGES-1];
  assign cab_rgb    = cab[5:0];
  assign cab_addry  = cab[ADDR_BITS+5:6];
  assign cab_sclk   = cab[ADDR_BITS+6];
  assign cab_latch  = cab[ADDR_BITS+7];
  assign cab_blank  = cab[ADDR_BITS+8];
  assign sclk_rise  = cab_sclk & ~sclk_d;
  assign latch_rise = cab_latch & ~latch_d;

`ifdef HUB75_RX_BLANK_QUAL_EN
  assign latch_ok  = latch_rise & cab_blank;
  assign latch_bad = latch_rise & ~cab_blank;
`else
  logic unused_blank;
  assign unused_blank = cab_blank;
  assign latch_ok     = latch_rise;
  assign latch_bad    = 1'b0;
`endif

  // A shift in the same cycle as a latch is folded into the latched row.
  always_comb begin
    sr_next  = sr;
    cnt_next = cnt;
    if (sclk_rise) begin
      sr_next = {sr[WIDTH-2:0], cab_rgb};
      if (cnt != CNT_MAX) cnt_next = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sync_q      <= '0;
      sclk_d      <= 1'b0;
      latch_d     <= 1'b0;
      sr          <= '0;
      hold        <= '0;
      cnt         <= '0;
      prev_addry  <= '0;
      lower       <= 1'b0;
      wr_valid    <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_rgb      <= '0;
      frame_start <= 1'b0;
      len_err     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], blank, latch, sclk, addry, rgb1, rgb0};
      sclk_d      <= cab_sclk;
      latch_d     <= cab_latch;
      sr          <= sr_next;
      cnt         <= cnt_next;
      frame_start <= 1'b0;
      len_err     <= latch_bad;
      case (state)
        IDLE: begin
          if (latch_ok) begin
            hold        <= sr_next;
            cnt         <= '0;
            len_err     <= (cnt_next != CNT_ROW);
            frame_start <= (cab_addry == '0) && (prev_addry != '0);
            prev_addry  <= cab_addry;
            wr_valid    <= 1'b1;
            wr_x        <= '0;
            wr_y        <= {1'b0, cab_addry};
            wr_rgb      <= sr_next[WIDTH-1][2:0];
            lower       <= 1'b0;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (latch_ok) begin
            overrun <= 1'b1;
            cnt     <= '0;
          end
          // hold[WIDTH-1] is always the column currently being presented
          if (wr_ready) begin
            if (!lower) begin
              lower  <= 1'b1;
              wr_y   <= {1'b1, wr_y[ADDR_BITS-1:0]};
              wr_rgb <= hold[WIDTH-1][5:3];
            end else if (wr_x == X_LAST) begin
              wr_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              lower  <= 1'b0;
              wr_x   <= wr_x + XW'(1);
              wr_y   <= {1'b0, wr_y[ADDR_BITS-1:0]};
              wr_rgb <= hold[WIDTH-2][2:0];
              hold   <= {hold[WIDTH-2:0], 6'b0};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: rows driven over the emulated cable, writes scoreboarded.
`timescale 1ns/1ps
module tb_hub75_rx;
  logic       clk = 1'b0, reset = 1'b1;
  logic       sclk = 1'b0, latch = 1'b0, blank = 1'b1, wr_ready = 1'b0;
  logic [4:0] addry = '0;
  logic [2:0] rgb0 = '0, rgb1 = '0;
  logic       wr_valid, frame_start, len_err, overrun;
  logic [5:0] wr_x, wr_y;
  logic [2:0] wr_rgb;

  int checks = 0, errors = 0;
  int n_len = 0, n_frame = 0;
  logic [5:0] q_x[$];
  logic [5:0] q_y[$];
  logic [2:0] q_rgb[$];
  logic       stall = 1'b0;
  logic [5:0] sx, sy;
  logic [2:0] srgb;

  always #5 clk = ~clk;

  hub75_rx #(.WIDTH(64), .ADDR_BITS(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .latch(latch), .blank(blank),
    .addry(addry), .rgb0(rgb0), .rgb1(rgb1),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .frame_start(frame_start), .len_err(len_err), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall && wr_valid) begin
      check("stall_x", wr_x, sx);
      check("stall_y", wr_y, sy);
      check("stall_rgb", wr_rgb, srgb);
    end
    stall = wr_valid && !wr_ready;
    sx = wr_x; sy = wr_y; srgb = wr_rgb;
    if (wr_valid && wr_ready) begin
      q_x.push_back(wr_x); q_y.push_back(wr_y); q_rgb.push_back(wr_rgb);
    end
    if (len_err) n_len++;
    if (frame_start) n_frame++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    q_x.delete(); q_y.delete(); q_rgb.delete();
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1 wr_ready = v;
  endtask

  task automatic shift_px(input logic [2:0] a, input logic [2:0] b);
    @(negedge clk); rgb0 = a; rgb1 = b; sclk = 1'b0;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    sclk = 1'b0;
  endtask

  // pat 0: only the first pixel lit (001/110); pat 1: ramp rgb0=i, rgb1=~i
  task automatic shift_row(input int n, input int pat);
    logic [2:0] v;
    for (int i = 0; i < n; i++) begin
      v = 3'(i);
      if (pat == 0) shift_px((i == 0) ? 3'b001 : 3'b000, (i == 0) ? 3'b110 : 3'b000);
      else shift_px(v, ~v);
    end
  endtask

  task automatic pulse_latch(input logic [4:0] y);
    @(negedge clk); addry = y; latch = 1'b1;
    repeat (4) @(negedge clk);
    latch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int c = 0;
    while (q_x.size() < n && c < budget) begin
      @(negedge clk); #1; c++;
    end
    check({tag, "_timeout"}, q_x.size() >= n, 1);
    repeat (20) @(negedge clk);
    #1;
    check({tag, "_count"}, q_x.size(), n);
    check({tag, "_idle"}, wr_valid, 0);
  endtask

  task automatic verify(input int pat, input int y, input string tag);
    int bad = 0, k, lo, ex_y, ex_rgb;
    for (int i = 0; i < q_x.size(); i++) begin
      k = i / 2; lo = i % 2;
      ex_y = lo ? y + 32 : y;
      if (pat == 0) ex_rgb = (k == 0) ? (lo ? 6 : 1) : 0;
      else ex_rgb = lo ? 7 - (k % 8) : k % 8;
      if (q_x[i] != 6'(k) || q_y[i] != 6'(ex_y) || q_rgb[i] != 3'(ex_rgb)) bad++;
    end
    check({tag, "_order"}, bad, 0);
  endtask

  initial begin
    int c, n0;
    repeat (3) @(negedge clk);
    check("rst_valid", wr_valid, 0);
    check("rst_x", wr_x, 0);
    check("rst_y", wr_y, 0);
    check("rst_rgb", wr_rgb, 0);
    check("rst_frame", frame_start, 0);
    check("rst_len", len_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // basic row
    set_ready(1'b1); clear_q(); n_len = 0; n_frame = 0;
    shift_row(64, 0); pulse_latch(5'd5);
    wait_writes(128, 2000, "basic");
    check("basic_w0_x", q_x[0], 0);
    check("basic_w0_y", q_y[0], 5);
    check("basic_w0_rgb", q_rgb[0], 1);
    check("basic_w1_x", q_x[1], 0);
    check("basic_w1_y", q_y[1], 37);
    check("basic_w1_rgb", q_rgb[1], 6);
    verify(0, 5, "basic");
    check("basic_len", n_len, 0);
    check("basic_frame", n_frame, 0);

    // backpressure with wr_ready alternating every cycle
    clear_q(); set_ready(1'b0);
    shift_row(64, 1); pulse_latch(5'd3);
    c = 0;
    while (q_x.size() < 128 && c < 2000) begin
      @(posedge clk); #1 wr_ready = ~wr_ready; c++;
    end
    set_ready(1'b1);
    wait_writes(128, 10, "bp");
    verify(1, 3, "bp");

    // short row
    clear_q(); n_len = 0;
    shift_row(63, 0); pulse_latch(5'd7);
    wait_writes(128, 2000, "len");
    check("len_pulses", n_len, 1);

    // frame wrap 30 -> 31 -> 0
    n_frame = 0;
    clear_q(); shift_row(64, 1); pulse_latch(5'd30); wait_writes(128, 2000, "wrap30");
    clear_q(); shift_row(64, 1); pulse_latch(5'd31); wait_writes(128, 2000, "wrap31");
    check("wrap_before0", n_frame, 0);
    clear_q(); shift_row(64, 1); pulse_latch(5'd0); wait_writes(128, 2000, "wrap0");
    verify(1, 0, "wrap0");
    check("wrap_frame", n_frame, 1);

    // overrun: second latch while the first row is stalled
    clear_q(); set_ready(1'b0); n_len = 0; n_frame = 0;
    shift_row(64, 1); pulse_latch(5'd9);
    check("ovr_clear", overrun, 0);
    shift_row(64, 0); pulse_latch(5'd11);
    check("ovr_set", overrun, 1);
    set_ready(1'b1);
    wait_writes(128, 2000, "ovr");
    verify(1, 9, "ovr");
    check("ovr_sticky", overrun, 1);
    check("ovr_len", n_len, 0);
    check("ovr_frame", n_frame, 0);

    // latch with blank low
    clear_q(); n_len = 0;
    blank = 1'b0;
    shift_row(64, 1); pulse_latch(5'd12);
`ifdef HUB75_RX_BLANK_QUAL_EN
    repeat (50) @(negedge clk);
    #1;
    check("blank_nowrites", q_x.size(), 0);
    check("blank_len", n_len, 1);
    blank = 1'b1;
    pulse_latch(5'd12);
    wait_writes(128, 2000, "blank_ok");
    verify(1, 12, "blank_ok");
    check("blank_ok_len", n_len, 1);
`else
    wait_writes(128, 2000, "blank_ign");
    verify(1, 12, "blank_ign");
    check("blank_ign_len", n_len, 0);
    blank = 1'b1;
`endif

    // reset after 10 writes of a row
    clear_q(); n_len = 0;
    shift_row(64, 1);
    @(negedge clk); addry = 5'd4; latch = 1'b1;
    c = 0;
    while (q_x.size() < 10 && c < 500) begin
      @(negedge clk); #1; c++;
    end
    reset = 1'b1; latch = 1'b0;
    n0 = q_x.size();
    check("mid_n0", n0, 10);
    @(negedge clk); #1;
    check("mid_valid", wr_valid, 0);
    check("mid_x", wr_x, 0);
    check("mid_y", wr_y, 0);
    check("mid_rgb", wr_rgb, 0);
    check("mid_ovr", overrun, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    check("mid_nomore", q_x.size(), n0);
    clear_q();
    shift_row(64, 1); pulse_latch(5'd6);
    wait_writes(128, 2000, "post_rst");
    verify(1, 6, "post_rst");
    check("post_rst_len", n_len, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receiving end of the HUB75 LED-panel cable; behaves like the panel's column shift registers.
- Oversamples SCLK, LATCH, BLANK, ADDRY and the RGB0/RGB1 lines in the system clock domain.
- Reconstructs each latched row and emits it as pixel writes toward a framebuffer.
- Used as a loopback/panel emulator so scan generators and picture logic can be checked on-board and in simulation without a panel.

Parameters:
- WIDTH, 64: columns per row (number of SCLK shifts per row).
- ADDR_BITS, 5: row-address width; the panel has 2*2^ADDR_BITS rows.
- SYNC_STAGES, 2: flip-flop synchroniser depth on every cable input.

Ports:
- clk  in  1  system clock; SCLK must be at most clk/4.
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  cable shift clock; data is sampled on its rising edge.
- latch  in  1  cable latch; a rising edge transfers the shifted row.
- blank  in  1  cable output-enable (high = blanked).
- addry  in  ADDR_BITS  cable row address.
- rgb0  in  3  upper-half pixel {B,G,R}.
- rgb1  in  3  lower-half pixel {B,G,R}.
- wr_valid  out  1  pixel write available.
- wr_ready  in  1  framebuffer accepts the write.
- wr_x  out  clog2(WIDTH)  column.
- wr_y  out  ADDR_BITS+1  row; upper half = addry, lower half = addry + 2^ADDR_BITS.
- wr_rgb  out  3  pixel {B,G,R}.
- frame_start  out  1  one-cycle pulse when a latched row address wraps to 0 from any nonzero address.
- len_err  out  1  one-cycle pulse when a latch arrives with shift count != WIDTH.
- overrun  out  1  sticky; set when a latch arrives while a row is still being emitted.

Behaviour:
- Reset values: wr_valid=0, wr_x=0, wr_y=0, wr_rgb=0, frame_start=0, len_err=0, overrun=0.
- Reset also clears the shift registers, shift counter, holding buffer, synchronisers, previous row address (0), and sets the FSM to IDLE.
- Reset mid-emission abandons the row; no further writes.
- Synchronisers: all cable inputs pass SYNC_STAGES flops. Edges are detected on the last stage versus one extra delayed copy.
- SCLK rising edge (synchronised):
  - Shift {rgb1,rgb0} into a WIDTH-deep shift register; the newest sample enters column 0 and older samples move toward WIDTH-1.
  - Increment shift counter, saturating at 2*WIDTH.
  - If more than WIDTH shifts occur, the oldest data falls off the end.
- LATCH rising edge (synchronised), in FSM IDLE:
  - Copy the shift register and addry into the holding buffer.
  - Pulse len_err if count != WIDTH.
  - Pulse frame_start if addry==0 and the previous latched addry was !=0; store addry as previous.
  - Clear the counter and go to EMIT.
- LATCH rising edge in FSM EMIT:
  - Set overrun; the new row is discarded.
  - Counter is still cleared; no len_err or frame_start is produced.
- Emission order (holding buffer is shifted out first-shifted-first):
  - The first-shifted pixel is column 0 and the last-shifted pixel is column WIDTH-1.
  - Emit column 0 upper, column 0 lower, column 1 upper, and so on, for 2*WIDTH writes.
- Handshake:
  - wr_valid rises the cycle after the latch edge is detected.
  - A write transfers when wr_valid && wr_ready; the next write is presented the following cycle.
  - With wr_ready held high, exactly one write per clk.
  - wr_x, wr_y and wr_rgb hold stable while wr_valid && !wr_ready.
- After the final transfer, wr_valid drops in the same cycle the next state becomes IDLE.
- SCLK shifting continues during EMIT; the next row accumulates independently of emission.
- A SCLK edge and a LATCH edge detected in the same cycle: the shift happens first and is included in the latched row.
- BLANK is ignored unless the optional feature is enabled.
- ADDRY is sampled only at the latch edge.

Optional Feature:
- Macro: HUB75_RX_BLANK_QUAL_EN
- Defined:
  - A latch edge is accepted only if synchronised blank==1 in the same cycle.
  - A latch with blank==0 is treated as a protocol violation: it pulses len_err, is not transferred, and leaves the counter and shift register untouched.
- Undefined: blank has no effect.

Test Plan:
- Reset mid-row: reset during EMIT after 10 writes -> wr_valid=0 next cycle, all outputs zero, no further writes, FSM returns to IDLE.
- Basic row: 64 SCLKs, first pixel rgb0=3'b001/rgb1=3'b110, the rest 0; addry=5; latch; wr_ready=1 -> 128 writes; first write (x=0,y=5,rgb=001); second write (x=0,y=37,rgb=110); all later writes rgb=0.
- Backpressure: toggle wr_ready 1010… -> writes stay in order, no value changes while stalled, 128 transfers total.
- Length error: 63 SCLKs then latch -> len_err pulses once; 128 writes still produced.
- Frame wrap: latch rows 30 then 31 then 0 -> frame_start pulses exactly once, on the row-0 latch.
- Overrun: hold wr_ready=0, issue a second latch -> overrun=1 and stays 1; only the first row's 128 writes are produced.
- With HUB75_RX_BLANK_QUAL_EN: latch while blank=0 -> no writes, len_err pulses; a latch with blank=1 afterwards emits the row.
